tx_module: RTL

UART transmit engine, the send-side counterpart of the UART receiver in the same core. Accepts a parallel word plus a per-frame configuration and serialises it LSB-first onto `uart_tx_o` as a standard UART frame: start bit, 5–8 data bits, optional even parity, 1–4 stop bits. Bit timing is derived from the shared 16× oversample `baud_en_i` strobe, so each bit lasts 16 strobes.

---
 rtl/tx_module.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/tx_module.sv
// UART transmit engine: serialises a word LSB-first as start, 5-8 data,
// optional even parity and 1-4 stop bits, 16 baud_en_i strobes per bit.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   baud_en_i              16x oversample strobe
//   tx_en_i                transmitter enable
//   tx_start_i             start request, taken only when tx_ready_o=1
//   tx_data_i              word to send (bits above frame length ignored)
//   tx_conf_i              {data[1:0], stop[1:0], parity_en}
//   uart_tx_o              serial line, idles high
//   tx_ready_o             idle and enabled
//   tx_busy_o              frame in progress
//   tx_done_o              one-clock pulse at frame completion
module tx_module #(
    parameter int MAX_UART_DATA_W      = 8,
    parameter int STOP_CONF_WIDTH      = 2,
    parameter int DATA_CONF_WIDTH      = 2,
    parameter int SAMPLE_COUNTER_WIDTH = 4,
    parameter int TOTAL_CONF_WIDTH     = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        baud_en_i,
    input  logic                        tx_en_i,
    input  logic                        tx_start_i,
    input  logic [MAX_UART_DATA_W-1:0]  tx_data_i,
    input  logic [TOTAL_CONF_WIDTH-1:0] tx_conf_i,
    output logic                        uart_tx_o,
    output logic                        tx_ready_o,
    output logic                        tx_busy_o,
    output logic                        tx_done_o
);

    typedef enum logic [2:0] {
        S_DISABLED,
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                            r_state, w_state_nxt;
    logic [MAX_UART_DATA_W-1:0]        r_data, w_data_nxt;
    logic [2:0]                        r_last_bit, w_last_bit_nxt;
    logic [STOP_CONF_WIDTH-1:0]        r_stop_last, w_stop_last_nxt;
    logic                              r_par_en, w_par_en_nxt;
    logic                              r_parity, w_parity_nxt;
    logic [SAMPLE_COUNTER_WIDTH-1:0]   r_smp_cnt, w_smp_cnt_nxt;
    logic [2:0]                        r_bit_cnt, w_bit_cnt_nxt;
    logic [STOP_CONF_WIDTH-1:0]        r_stop_cnt, w_stop_cnt_nxt;
    logic                              r_tx, w_tx_nxt;
    logic                              r_ready, w_ready_nxt;
    logic                              r_busy, w_busy_nxt;
    logic                              r_done, w_done_nxt;

    logic [DATA_CONF_WIDTH-1:0]        w_conf_data;
    logic [STOP_CONF_WIDTH-1:0]        w_conf_stop;
    logic                              w_conf_par;
    logic [MAX_UART_DATA_W-1:0]        w_mask;
    logic [MAX_UART_DATA_W-1:0]        w_data_masked;
    logic                              w_wrap;

    assign w_conf_data = tx_conf_i[TOTAL_CONF_WIDTH-1 -: DATA_CONF_WIDTH];
    assign w_conf_stop = tx_conf_i[STOP_CONF_WIDTH:1];
    assign w_conf_par  = tx_conf_i[0];

    // Unused high data bits are zeroed so they cannot reach the parity.
    assign w_mask = {MAX_UART_DATA_W{1'b1}}
                    >> (DATA_CONF_WIDTH'(3) - w_conf_data);
    assign w_data_masked = tx_data_i & w_mask;

    // Last strobe of the current bit period.
    assign w_wrap = baud_en_i && (&r_smp_cnt);

    always_comb begin
        w_state_nxt     = r_state;
        w_data_nxt      = r_data;
        w_last_bit_nxt  = r_last_bit;
        w_stop_last_nxt = r_stop_last;
        w_par_en_nxt    = r_par_en;
        w_parity_nxt    = r_parity;
        w_smp_cnt_nxt   = r_smp_cnt;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_stop_cnt_nxt  = r_stop_cnt;
        w_done_nxt      = 1'b0;

        // Counter wraps 15 -> 0 by natural overflow.
        if (r_busy && baud_en_i) begin
            w_smp_cnt_nxt = r_smp_cnt + SAMPLE_COUNTER_WIDTH'(1);
        end

        unique case (r_state)
            S_DISABLED: begin
                if (tx_en_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (!tx_en_i) begin
                    w_state_nxt = S_DISABLED;
                end else if (tx_start_i) begin
                    w_state_nxt     = S_START;
                    w_data_nxt      = w_data_masked;
                    w_last_bit_nxt  = {1'b0, w_conf_data} + 3'd4;
                    w_stop_last_nxt = w_conf_stop;
                    w_par_en_nxt    = w_conf_par;
                    w_parity_nxt    = ^w_data_masked;
                    w_smp_cnt_nxt   = '0;
                    w_bit_cnt_nxt   = '0;
                    w_stop_cnt_nxt  = '0;
                end
            end
            S_START: begin
                if (w_wrap) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_wrap) begin
                    if (r_bit_cnt == r_last_bit) begin
                        w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_wrap) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_wrap) begin
                    if (r_stop_cnt == r_stop_last) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = tx_en_i ? S_IDLE : S_DISABLED;
                    end else begin
                        w_stop_cnt_nxt = r_stop_cnt
                                         + STOP_CONF_WIDTH'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_DISABLED;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register
    // on the same edge as the state change.
    always_comb begin
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
        w_ready_nxt = (w_state_nxt == S_IDLE);
        unique case (w_state_nxt)
            S_START: begin
                w_tx_nxt   = 1'b0;
                w_busy_nxt = 1'b1;
            end
            S_DATA: begin
                w_tx_nxt   = w_data_nxt[w_bit_cnt_nxt];
                w_busy_nxt = 1'b1;
            end
            S_PARITY: begin
                w_tx_nxt   = w_parity_nxt;
                w_busy_nxt = 1'b1;
            end
            S_STOP: begin
                w_busy_nxt = 1'b1;
            end
            default: begin
                w_tx_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_DISABLED;
            r_data      <= '0;
            r_last_bit  <= '0;
            r_stop_last <= '0;
            r_par_en    <= 1'b0;
            r_parity    <= 1'b0;
            r_smp_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_stop_cnt  <= '0;
            r_tx        <= 1'b1;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_data      <= w_data_nxt;
            r_last_bit  <= w_last_bit_nxt;
            r_stop_last <= w_stop_last_nxt;
            r_par_en    <= w_par_en_nxt;
            r_parity    <= w_parity_nxt;
            r_smp_cnt   <= w_smp_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_stop_cnt  <= w_stop_cnt_nxt;
            r_tx        <= w_tx_nxt;
            r_ready     <= w_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign uart_tx_o  = r_tx;
    assign tx_ready_o = r_ready;
    assign tx_busy_o  = r_busy;
    assign tx_done_o  = r_done;

endmodule
